sp_rom_reader: RTL and testbench
================================

SP_ROM_READER -- requirements
Module: sp_rom_reader

Interface
REQ-001 Parameter DATA_W, default 8, ROM word width in bits.
REQ-002 Parameter ADDR_W, default 10, ROM address width; ROM depth 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request; sampled only when busy=0.
REQ-006 base_addr  input  ADDR_W  first ROM address; sampled with start.
REQ-007 len  input  ADDR_W+1  word count, 0..2**ADDR_W; sampled with start.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at end of transfer.
REQ-010 rom_r_en  output  1  read enable to single-port ROM.
REQ-011 rom_addr  output  ADDR_W  ROM read address.
REQ-012 rom_rdata  input  DATA_W  ROM data, valid the cycle after rom_r_en=1.
REQ-013 m_valid  output  1  stream word available.
REQ-014 m_data  output  DATA_W  stream word.
REQ-015 m_ready  input  1  consumer accepts when m_valid&m_ready.

Function
REQ-016 States IDLE, RUN; IDLE->RUN on start&!busy&len!=0; RUN->IDLE on acceptance of the last word.
REQ-017 start with len=0 produces done=1 the next cycle, no ROM reads, busy stays 0.
REQ-018 start while busy=1 is ignored; base_addr/len latched only on accepted start.
REQ-019 Read issue (rom_r_en=1) iff state RUN, words remaining to issue >0, and fifo_count+inflight+1<=4; rom_r_en combinational from registered state.
REQ-020 inflight = registered copy of previous cycle's rom_r_en; rom_rdata written into FIFO when inflight=1.
REQ-021 rom_addr increments by 1 after each issue, modulo 2**ADDR_W (2**ADDR_W-1 wraps to 0).
REQ-022 Internal FIFO depth 4, FIFO order; m_valid=!fifo_empty, m_data=FIFO head (registered).
REQ-023 Latency: start accepted at edge E0 -> rom_r_en=1 in cycle after E0 -> m_valid=1 two cycles later (3 cycles start-to-data).
REQ-024 With m_ready held 1, throughput 1 word/cycle after initial latency.
REQ-025 m_ready=0 stalls issue when FIFO plus inflight would exceed 4; no word lost or duplicated; m_valid/m_data stable until accepted.
REQ-026 Simultaneous FIFO write and pop on full FIFO never occurs by REQ-019; simultaneous write and pop otherwise keeps count unchanged.
REQ-027 done=1 for exactly the cycle following acceptance of the last word; busy=0 in that same cycle; new start accepted that cycle.
REQ-028 len=2**ADDR_W reads every address exactly once, wrapping.

Reset
REQ-029 rst=1 forces IDLE, busy=0, done=0, rom_r_en=0, inflight=0, FIFO empty, m_valid=0, rom_addr=0, counters 0 at the next edge.
REQ-030 rst mid-transfer abandons transfer; no done pulse; rom_rdata arriving after reset discarded.
REQ-031 m_data value after reset don't-care; all other outputs defined.

Structure
REQ-032 Shared header holds FIFO depth constant (4) and state encodings (IDLE=0, RUN=1).
REQ-033 One sub-module: sp_rom_reader_fifo (depth 4, DATA_W wide, count output, synchronous rst).
REQ-034 Estimated 150-250 RTL lines total.

Verification (ROM model: sp_rom behaviour, rom[i]=i mod 256, DATA_W=8, ADDR_W=10)
REQ-035 start, base=0x010, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, first 3 cycles after start, done one cycle after last.
REQ-036 base=0x3FE, len=4 -> data 0xFE,0xFF,0x00,0x01; rom_addr sequence 3FE,3FF,000,001.
REQ-037 len=8, m_ready toggling 1/0 each cycle and a 10-cycle 0 stall -> exactly 8 words in order 0..7 offset, rom_r_en never issues with fifo_count+inflight=4.
REQ-038 len=0 -> done next cycle, rom_r_en never asserted; second start during busy transfer ignored (word count unchanged).
REQ-039 rst asserted mid-transfer of len=16 after 5 words -> all outputs reset next cycle, no done; following start base=0, len=2 -> 0x00,0x01.
REQ-040 len=1024, base=0x200, m_ready=1 -> 1024 words, each address once, 1 word/cycle sustained.

Source files
------------

// File: rtl/sp_rom_reader_pkg.sv
// Shared constants and state encoding for the single-port ROM stream reader.
// The reader and its output FIFO both import this package.
package sp_rom_reader_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Pointer advance; depth is a power of two so natural wrap is correct.
    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
        return p + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/sp_rom_reader_fifo.sv
// Four-entry FIFO buffering ROM words between read issue and the stream consumer.
// Head word is read straight from the storage registers.
module sp_rom_reader_fifo
    import sp_rom_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_empty
);

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy; a write and a pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {FIFO_PTR_W{1'b0}};
            r_rd_ptr <= {FIFO_PTR_W{1'b0}};
            r_count  <= {FIFO_CNT_W{1'b0}};
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == {FIFO_CNT_W{1'b0}});

endmodule

// File: rtl/sp_rom_reader.sv
// Reads len consecutive words from a single-port ROM starting at base_addr and
// streams them out over a valid/ready interface, with a done pulse at the end.
module sp_rom_reader
    import sp_rom_reader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    localparam int LEN_W = ADDR_W + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [LEN_W-1:0]      r_issue_left;
    logic [LEN_W-1:0]      r_accept_left;
    logic                  r_inflight;
    logic                  r_done;
    logic [FIFO_CNT_W-1:0] w_fifo_count;
    logic                  w_fifo_empty;
    logic [FIFO_CNT_W:0]   w_pending;
    logic                  w_start_ok;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_issue;

    // Words buffered plus the one possibly in flight must leave room for one more.
    assign w_pending  = {1'b0, w_fifo_count} + {{FIFO_CNT_W{1'b0}}, r_inflight};
    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_pop      = m_valid && m_ready;
    assign w_last_pop = (r_state == ST_RUN) && w_pop && (r_accept_left == LEN_W'(1));
    assign w_issue    = (r_state == ST_RUN) && (r_issue_left != {LEN_W{1'b0}})
                        && (w_pending < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a zero-length request never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok && (len != {LEN_W{1'b0}})) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address, issue/accept counters, in-flight marker and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= {ADDR_W{1'b0}};
            r_issue_left  <= {LEN_W{1'b0}};
            r_accept_left <= {LEN_W{1'b0}};
            r_inflight    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= (w_start_ok && (len == {LEN_W{1'b0}})) || w_last_pop;
            if (w_start_ok) begin
                r_addr        <= base_addr;
                r_issue_left  <= len;
                r_accept_left <= len;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - LEN_W'(1);
                end
                if (w_pop) begin
                    r_accept_left <= r_accept_left - LEN_W'(1);
                end
            end
        end
    end

    sp_rom_reader_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_inflight),
        .i_wr_data (rom_rdata),
        .i_rd_en   (w_pop),
        .o_rd_data (m_data),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    assign busy     = (r_state == ST_RUN);
    assign done     = r_done;
    assign rom_r_en = w_issue;
    assign rom_addr = r_addr;
    assign m_valid  = !w_fifo_empty;

endmodule

// File: tb/tb_sp_rom_reader.sv
// Directed bench for sp_rom_reader: table of transfers plus hand-written
// sequences for zero length and mid-transfer reset. ROM holds rom[i] = i mod 256.
module tb_sp_rom_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        rom_r_en;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_rdata;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        int          mode;       // 0: ready=1, 1: toggle, 2: toggle + 10-cycle stall
        int          restart_k;  // cycle at which an extra start is pulsed, -1 none
        logic [7:0]  exp_last;
        int          exp_done_k; // -1 when not checked
    } vec_t;

    vec_t vecs[7];

    sp_rom_reader #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_r_en  (rom_r_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (rom_r_en) rom_rdata <= rom_addr[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 2 && k >= 6 && k < 16) return 1'b0;
        return (k % 2) == 0;
    endfunction

    // Runs one transfer from a post-edge sample point; returns at the done sample.
    task automatic run_xfer(input logic [9:0] b, input logic [10:0] n, input int mode,
                            input int restart_k, input logic [7:0] exp_last, input int exp_done_k);
        int         issued;
        int         accepted;
        int         first_k;
        int         last_pop_k;
        logic       got_done;
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [7:0] last_data;
        issued = 0; accepted = 0; first_k = -1; last_pop_k = -10;
        got_done = 1'b0; prev_hold = 1'b0; prev_data = 8'h00; last_data = 8'h00;
        start = 1'b1; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2000 && !got_done; k++) begin
            if (k == restart_k) begin
                start = 1'b1; base_addr = 10'h300; len = 11'd2;
            end else if (k == restart_k + 1) begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_after_last", 32'(k), 32'(last_pop_k + 1));
                chk("word_count", 32'(accepted), 32'(n));
                chk("issue_count", 32'(issued), 32'(n));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("last_word", 32'(last_data), 32'(exp_last));
                if (exp_done_k >= 0) chk("done_cycle", 32'(k), 32'(exp_done_k));
            end else begin
                chk("busy_during", 32'(busy), 32'd1);
                if (prev_hold) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'(m_data), 32'(prev_data));
                end
                if (rom_r_en) begin
                    chk("issue_limit", 32'((issued - accepted) < 4), 32'd1);
                    chk("rom_addr", 32'(rom_addr), 32'((int'(b) + issued) % 1024));
                    issued++;
                end
                if (m_valid && first_k < 0) begin
                    first_k = k;
                    if (mode == 0) chk("first_latency", 32'(k), 32'd2);
                end
                m_ready = ready_of(mode, k);
                if (m_valid && m_ready) begin
                    chk("m_data", 32'(m_data), 32'(((int'(b) + accepted) % 1024) % 256));
                    last_data = m_data;
                    accepted++;
                    last_pop_k = k;
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                @(posedge clk); #1;
            end
        end
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; start = 1'b0; base_addr = 10'h000; len = 11'd0; m_ready = 1'b0;
        vecs[0] = '{10'h010, 11'd4,    0, -1, 8'h13, 6};
        vecs[1] = '{10'h3FE, 11'd4,    0, -1, 8'h01, 6};
        vecs[2] = '{10'h000, 11'd8,    2, -1, 8'h07, -1};
        vecs[3] = '{10'h100, 11'd1,    0, -1, 8'h00, 3};
        vecs[4] = '{10'h200, 11'd1024, 0, -1, 8'hFF, 1026};
        vecs[5] = '{10'h005, 11'd8,    1, -1, 8'h0C, -1};
        vecs[6] = '{10'h020, 11'd4,    0,  1, 8'h23, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_r_en", 32'(rom_r_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart_k,
                     vecs[i].exp_last, vecs[i].exp_done_k);
        end

        // Zero-length request: immediate done, no reads, never busy.
        start = 1'b1; base_addr = 10'h055; len = 11'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_r_en", 32'(rom_r_en), 32'd0);
        @(posedge clk); #1;
        chk("len0_done_clr", 32'(done), 32'd0);
        chk("len0_r_en2", 32'(rom_r_en), 32'd0);
        chk("len0_valid", 32'(m_valid), 32'd0);

        // Reset after five accepted words of a 16-word transfer.
        start = 1'b1; base_addr = 10'h000; len = 11'd16; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 5; k++) begin
            if (m_valid && m_ready) cnt++;
            if (cnt < 5) begin @(posedge clk); #1; end
        end
        chk("pre_rst_words", 32'(cnt), 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_r_en", 32'(rom_r_en), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        run_xfer(10'h000, 11'd2, 0, -1, 8'h01, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
